// File: rtl/bvashr_witness_checker.sv
// Serial bvashr(s, x) evaluator that checks a candidate witness x against a target t.
// Optional BVASHR_EARLY_EXIT_EN stops shifting once the value is sign-saturated.
module bvashr_witness_checker #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] s,
   input  logic [W-1:0] t,
   input  logic [W-1:0] x,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_result,
   output logic         out_eq
);

   localparam int CW = $clog2(W + 1);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t        state, state_nxt;
   logic [W-1:0]  sh;
   logic [W-1:0]  t_q;
   logic [CW-1:0] cnt;

   logic [W-1:0]  sh_shift;
   logic [CW-1:0] cnt_dec;
   logic [CW-1:0] cnt_init;
   logic          exit_acc;
   logic          exit_shift;

   // Amounts of W or more saturate to W: the result is then pure sign fill.
   assign cnt_init = (x >= W) ? CW'(W) : x[CW-1:0];
   assign sh_shift = {sh[W-1], sh[W-1:1]};
   assign cnt_dec  = cnt - 1'b1;

`ifdef BVASHR_EARLY_EXIT_EN
   // An all-zeros or all-ones value is a fixed point of the arithmetic shift.
   assign exit_acc   = (s == '0) || (s == '1);
   assign exit_shift = (sh_shift == '0) || (sh_shift == '1);
`else
   assign exit_acc   = 1'b0;
   assign exit_shift = 1'b0;
`endif

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values; blocking here would create order-dependent races.
   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // NOTE: the default assignment first keeps this block free of inferred latches.
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:  if (in_valid) state_nxt = (cnt_init == '0 || exit_acc) ? DONE : SHIFT;
         SHIFT: state_nxt = (cnt_dec == '0 || exit_shift) ? DONE : SHIFT;
         DONE:  if (out_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      in_ready  = (state == IDLE);
      out_valid = (state == DONE);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sh         <= '0;
         t_q        <= '0;
         cnt        <= '0;
         out_result <= '0;
         out_eq     <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (in_valid) begin
                  t_q <= t;
                  sh  <= s;
                  cnt <= cnt_init;
                  if (state_nxt == DONE) begin
                     out_result <= s;
                     out_eq     <= (s == t);
                  end
               end
            end
            SHIFT: begin
               sh  <= sh_shift;
               cnt <= cnt_dec;
               if (state_nxt == DONE) begin
                  out_result <= sh_shift;
                  out_eq     <= (sh_shift == t_q);
               end
            end
            default: ;
         endcase
      end
   end

endmodule
